traffic_intersection_ctrl: RTL and testbench

TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

---
 rtl/traffic_light_pkg.sv | 32 +++
 rtl/traffic_intersection_ctrl_phase_timer.sv | 46 ++++
 rtl/traffic_intersection_ctrl.sv | 150 +++++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// ============================================================================
// Module   : traffic_light_pkg
// Brief    : Lamp/controller enums and default phase durations for the
//            intersection controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package traffic_light_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        RED    = 2'd2
    } trafic_light_t;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GO      = 2'd1,
        WARN    = 2'd2,
        FLASH   = 2'd3
    } ctrl_state_t;

    localparam int DEF_NUM_DIR        = 2;
    localparam int DEF_GREEN_CYCLES   = 10;
    localparam int DEF_YELLOW_CYCLES  = 3;
    localparam int DEF_ALL_RED_CYCLES = 2;
    localparam int DEF_CNT_W          = 8;

endpackage

`default_nettype wire

// File: rtl/traffic_intersection_ctrl_phase_timer.sv
// ============================================================================
// Module   : phase_timer
// Brief    : Phase counter 0..i_term with enable, synchronous clear and
//            terminal-count flag; wraps to zero on an enabled terminal count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module phase_timer
    import traffic_light_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign o_tc = (cnt_q == i_term);

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = o_tc ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/traffic_intersection_ctrl.sv
// ============================================================================
// Module   : traffic_intersection_ctrl
// Brief    : Round-robin intersection sequencer with sticky pedestrian
//            requests and a flashing fault/night mode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module traffic_intersection_ctrl
    import traffic_light_pkg::*;
#(
    parameter int NUM_DIR        = DEF_NUM_DIR,
    parameter int GREEN_CYCLES   = DEF_GREEN_CYCLES,
    parameter int YELLOW_CYCLES  = DEF_YELLOW_CYCLES,
    parameter int ALL_RED_CYCLES = DEF_ALL_RED_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         asyn_reset,
    input  logic                         enable,
    input  logic                         flash_mode,
    input  logic [NUM_DIR-1:0]           ped_req,
    output trafic_light_t [NUM_DIR-1:0]  lights,
    output logic [NUM_DIR-1:0]           ped_walk,
    output logic [$clog2(NUM_DIR)-1:0]   active_dir
);

    localparam int               DIR_W    = $clog2(NUM_DIR);
    localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_DIR - 1);

    ctrl_state_t        state_q, state_d;
    logic [DIR_W-1:0]   active_dir_q, active_dir_d;
    logic [NUM_DIR-1:0] pending_q, pending_d;
    logic               walk_q, walk_d;
    logic               flash_phase_q, flash_phase_d;

    logic [CNT_W-1:0]   w_term;
    logic               w_tc;
    logic               w_clear;

    always_comb begin
        case (state_q)
            ALL_RED: w_term = CNT_W'(ALL_RED_CYCLES - 1);
            GO:      w_term = CNT_W'(GREEN_CYCLES - 1);
            default: w_term = CNT_W'(YELLOW_CYCLES - 1);
        endcase
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk     (clk),
        .rst     (asyn_reset),
        .i_en    (enable),
        .i_clear (w_clear),
        .i_term  (w_term),
        .o_tc    (w_tc)
    );

    always_comb begin
        state_d       = state_q;
        active_dir_d  = active_dir_q;
        pending_d     = pending_q | ped_req;
        walk_d        = walk_q;
        flash_phase_d = flash_phase_q;
        w_clear       = 1'b0;
        if (enable) begin
            case (state_q)
                ALL_RED: begin
                    if (w_tc) begin
                        if (flash_mode) begin
                            state_d       = FLASH;
                            flash_phase_d = 1'b0;
                        end else begin
                            // Same-cycle requests are already merged into pending_d.
                            state_d                 = GO;
                            walk_d                  = pending_d[active_dir_q];
                            pending_d[active_dir_q] = 1'b0;
                        end
                    end
                end
                GO: begin
                    if (flash_mode) begin
                        state_d = WARN;
                        w_clear = 1'b1;
                    end else if (w_tc) begin
                        state_d = WARN;
                    end
                end
                WARN: begin
                    if (w_tc) begin
                        state_d      = ALL_RED;
                        active_dir_d = (active_dir_q == LAST_DIR) ? '0
                                                                  : active_dir_q + DIR_W'(1);
                    end
                end
                FLASH: begin
                    if (!flash_mode) begin
                        state_d      = ALL_RED;
                        active_dir_d = '0;
                        w_clear      = 1'b1;
                    end else if (w_tc) begin
                        flash_phase_d = ~flash_phase_q;
                    end
                end
                default: state_d = ALL_RED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state_q       <= ALL_RED;
            active_dir_q  <= '0;
            pending_q     <= '0;
            walk_q        <= 1'b0;
            flash_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_dir_q  <= active_dir_d;
            pending_q     <= pending_d;
            walk_q        <= walk_d;
            flash_phase_q <= flash_phase_d;
        end
    end

    // Lamp and walk outputs depend on registered state only.
    always_comb begin
        for (int i = 0; i < NUM_DIR; i++) begin
            lights[i]   = RED;
            ped_walk[i] = 1'b0;
            if (active_dir_q == DIR_W'(i)) begin
                if (state_q == GO) begin
                    lights[i]   = GREEN;
                    ped_walk[i] = walk_q;
                end else if (state_q == WARN) begin
                    lights[i] = YELLOW;
                end
            end
            if (state_q == FLASH && !flash_phase_q) begin
                lights[i] = YELLOW;
            end
        end
    end

    assign active_dir = active_dir_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_intersection_ctrl.sv
// ============================================================================
// Module   : tb_traffic_intersection_ctrl
// Brief    : Directed scenarios plus randomized traffic against a
//            remaining-time reference model of the intersection controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_traffic_intersection_ctrl;
    import traffic_light_pkg::*;

    localparam int ND = 3;
    localparam int G  = 4;
    localparam int Y  = 2;
    localparam int R  = 1;

    localparam int M_CLEAR = 0;
    localparam int M_GREEN = 1;
    localparam int M_AMBER = 2;
    localparam int M_BLINK = 3;

    logic                    clk = 1'b0;
    logic                    asyn_reset;
    logic                    enable;
    logic                    flash_mode;
    logic [ND-1:0]           ped_req;
    trafic_light_t [ND-1:0]  lights;
    logic [ND-1:0]           ped_walk;
    logic [1:0]              active_dir;

    int checks   = 0;
    int failures = 0;

    int       m_mode;
    int       m_left;
    int       m_dir;
    int       m_blink;
    bit       m_walk;
    bit [ND-1:0] m_pend;

    traffic_intersection_ctrl #(
        .NUM_DIR        (ND),
        .GREEN_CYCLES   (G),
        .YELLOW_CYCLES  (Y),
        .ALL_RED_CYCLES (R),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .enable     (enable),
        .flash_mode (flash_mode),
        .ped_req    (ped_req),
        .lights     (lights),
        .ped_walk   (ped_walk),
        .active_dir (active_dir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode  = M_CLEAR;
        m_left  = R;
        m_dir   = 0;
        m_blink = 0;
        m_walk  = 1'b0;
        m_pend  = '0;
    endfunction

    function automatic void model_step(input bit en, input bit fl, input bit [ND-1:0] req);
        m_pend = m_pend | req;
        if (!en) return;
        case (m_mode)
            M_CLEAR: begin
                m_left--;
                if (m_left == 0) begin
                    if (fl) begin
                        m_mode  = M_BLINK;
                        m_blink = 0;
                    end else begin
                        m_mode        = M_GREEN;
                        m_left        = G;
                        m_walk        = m_pend[m_dir];
                        m_pend[m_dir] = 1'b0;
                    end
                end
            end
            M_GREEN: begin
                m_left--;
                if (fl || m_left == 0) begin
                    m_mode = M_AMBER;
                    m_left = Y;
                end
            end
            M_AMBER: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = M_CLEAR;
                    m_left = R;
                    m_dir  = (m_dir + 1) % ND;
                end
            end
            default: begin
                if (!fl) begin
                    m_mode = M_CLEAR;
                    m_left = R;
                    m_dir  = 0;
                end else begin
                    m_blink++;
                end
            end
        endcase
    endfunction

    function automatic trafic_light_t exp_light(input int i);
        case (m_mode)
            M_GREEN: return (i == m_dir) ? GREEN : RED;
            M_AMBER: return (i == m_dir) ? YELLOW : RED;
            M_BLINK: return (((m_blink / Y) % 2) == 0) ? YELLOW : RED;
            default: return RED;
        endcase
    endfunction

    function automatic int exp_walk();
        return (m_mode == M_GREEN && m_walk) ? (1 << m_dir) : 0;
    endfunction

    // Model comparison on the falling edge, clear of the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < ND; i++) begin
            chk("model_light", int'(lights[i]), int'(exp_light(i)));
        end
        chk("model_walk", int'(ped_walk), exp_walk());
        chk("model_dir", int'(active_dir), m_dir);
    end

    int  nr;
    logic one_ok;
    always_comb begin
        nr = 0;
        for (int i = 0; i < ND; i++) begin
            if (lights[i] != RED) nr++;
        end
        one_ok = (nr <= 1) || (lights == {ND{YELLOW}});
    end

    a_one_non_red: assert property (@(negedge clk) disable iff (asyn_reset) one_ok)
        else $error("FAIL one_non_red lights=%b", lights);

    task automatic cycle();
        @(posedge clk);
        if (!asyn_reset) model_step(enable, flash_mode, ped_req);
        #1;
    endtask

    task automatic all_red_check(input string name);
        for (int i = 0; i < ND; i++) chk(name, int'(lights[i]), int'(RED));
    endtask

    task automatic reset_mid();
        #2;
        asyn_reset = 1'b1;
        model_reset();
        #1;
        all_red_check("async_reset_red");
        chk("async_reset_walk", int'(ped_walk), 0);
        chk("async_reset_dir", int'(active_dir), 0);
        cycle();
        asyn_reset = 1'b0;
    endtask

    initial begin
        asyn_reset = 1'b1;
        enable     = 1'b0;
        flash_mode = 1'b0;
        ped_req    = '0;
        model_reset();
        #1;
        all_red_check("reset_red");
        chk("reset_dir", int'(active_dir), 0);
        chk("reset_walk", int'(ped_walk), 0);
        repeat (2) cycle();
        asyn_reset = 1'b0;

        for (int k = 1; k <= 65; k++) begin
            enable     = !(k >= 37 && k <= 41);
            flash_mode = (k >= 49 && k <= 59);
            ped_req    = (k == 2) ? 3'b010 : (k == 62) ? 3'b100 : 3'b000;
            cycle();
            case (k)
                1:  begin chk("k1_green0", int'(lights[0]), int'(GREEN));
                          chk("k1_red1", int'(lights[1]), int'(RED)); end
                4:  chk("k4_green0", int'(lights[0]), int'(GREEN));
                5:  chk("k5_yellow0", int'(lights[0]), int'(YELLOW));
                7:  begin all_red_check("k7_allred"); chk("k7_dir1", int'(active_dir), 1); end
                8:  begin chk("k8_green1", int'(lights[1]), int'(GREEN));
                          chk("k8_walk1", int'(ped_walk), 2); end
                11: chk("k11_walk1", int'(ped_walk), 2);
                12: begin chk("k12_walk_off", int'(ped_walk), 0);
                          chk("k12_yellow1", int'(lights[1]), int'(YELLOW)); end
                15: chk("k15_green2", int'(lights[2]), int'(GREEN));
                21: chk("k21_dir_wrap", int'(active_dir), 0);
                29: begin chk("k29_green1", int'(lights[1]), int'(GREEN));
                          chk("k29_no_repeat", int'(ped_walk), 0); end
                44: chk("k44_stretched_green", int'(lights[2]), int'(GREEN));
                45: chk("k45_yellow2", int'(lights[2]), int'(YELLOW));
                50: chk("k50_flash_warn", int'(lights[0]), int'(YELLOW));
                51: begin all_red_check("k51_allred"); chk("k51_dir1", int'(active_dir), 1); end
                52: for (int i = 0; i < ND; i++) chk("k52_flash_y", int'(lights[i]), int'(YELLOW));
                54: all_red_check("k54_flash_r");
                56: for (int i = 0; i < ND; i++) chk("k56_flash_y", int'(lights[i]), int'(YELLOW));
                60: begin all_red_check("k60_allred"); chk("k60_dir0", int'(active_dir), 0); end
                61: chk("k61_green0", int'(lights[0]), int'(GREEN));
                65: begin
                    chk("k65_yellow0", int'(lights[0]), int'(YELLOW));
                    reset_mid();
                end
                default: ;
            endcase
        end

        enable     = 1'b1;
        flash_mode = 1'b0;
        ped_req    = '0;
        for (int k = 1; k <= 15; k++) begin
            cycle();
            if (k == 1) chk("post_reset_green0", int'(lights[0]), int'(GREEN));
            if (k == 15) begin
                chk("post_reset_green2", int'(lights[2]), int'(GREEN));
                chk("post_reset_pending_cleared", int'(ped_walk), 0);
            end
        end

        for (int n = 0; n < 1500; n++) begin
            enable  = ($urandom_range(7) != 0);
            if ($urandom_range(49) == 0) flash_mode = ~flash_mode;
            for (int i = 0; i < ND; i++) ped_req[i] = ($urandom_range(9) == 0);
            cycle();
            if ($urandom_range(499) == 0) reset_mid();
        end

        flash_mode = 1'b0;
        ped_req    = '0;
        repeat (20) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
